ascon_state_select_reg: RTL and testbench

//  Parametrised N-source state selector fused with the ASCON state register.

---
 rtl/ascon_state_select_reg_if.sv | 35 +++
 rtl/ascon_state_select_reg.sv | 110 +++++++++++
 tb/tb_ascon_state_select_reg.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/ascon_state_select_reg_if.sv
// Bus between the ASCON control FSM and the state-select register.
// The master drives candidate states and load/inject controls; the slave
// returns the registered state and its status flags.
interface ascon_state_select_reg_if #(
    parameter int NB_SRC   = 4,
    parameter int NB_WORDS = 5,
    parameter int WORD_W   = 64,
    parameter int CNT_W    = 8
) ();
    localparam int ST_W   = NB_WORDS * WORD_W;
    localparam int SEL_W  = (NB_SRC > 1) ? $clog2(NB_SRC) : 1;
    localparam int WSEL_W = (NB_WORDS > 1) ? $clog2(NB_WORDS) : 1;

    logic [NB_SRC*ST_W-1:0] src_i;
    logic [SEL_W-1:0]       sel_i;
    logic                   load_i;
    logic                   clear_i;
    logic                   inj_en_i;
    logic [WSEL_W-1:0]      inj_word_i;
    logic [WORD_W-1:0]      inj_data_i;
    logic [ST_W-1:0]        state_o;
    logic                   state_valid_o;
    logic                   sel_err_o;
    logic [CNT_W-1:0]       load_cnt_o;

    modport master (
        output src_i, sel_i, load_i, clear_i, inj_en_i, inj_word_i, inj_data_i,
        input  state_o, state_valid_o, sel_err_o, load_cnt_o
    );

    modport slave (
        input  src_i, sel_i, load_i, clear_i, inj_en_i, inj_word_i, inj_data_i,
        output state_o, state_valid_o, sel_err_o, load_cnt_o
    );
endinterface

// File: rtl/ascon_state_select_reg.sv
// N-source ASCON state selector fused with the state register.
// Selects one candidate state, optionally XORs one data word into it, and
// registers the result. Tracks validity, counts accepted loads (saturating)
// and raises a sticky flag on out-of-range source or word indices.
module ascon_state_select_reg #(
    parameter int NB_SRC   = 4,
    parameter int NB_WORDS = 5,
    parameter int WORD_W   = 64,
    parameter int CNT_W    = 8
) (
    input  logic                   clock_i,
    input  logic                   resetb_i,
    ascon_state_select_reg_if.slave bus
);
    localparam int ST_W    = NB_WORDS * WORD_W;
    localparam int SEL_W   = (NB_SRC > 1) ? $clog2(NB_SRC) : 1;
    localparam int WSEL_W  = (NB_WORDS > 1) ? $clog2(NB_WORDS) : 1;
    localparam int SEL_PW  = SEL_W + 1;
    localparam int WSEL_PW = WSEL_W + 1;
    // Limits carry one extra bit so a power-of-2 count is representable.
    localparam logic [SEL_PW-1:0]  SRC_LIM  = SEL_PW'(NB_SRC);
    localparam logic [WSEL_PW-1:0] WORD_LIM = WSEL_PW'(NB_WORDS);

    typedef enum logic {EMPTY = 1'b0, VALID = 1'b1} fsm_t;

    fsm_t              fsm_p1, fsm_d;
    logic [ST_W-1:0]   state_p1, state_d;
    logic              sel_err_p1, sel_err_d;
    logic [CNT_W-1:0]  cnt_p1, cnt_d;
    logic [ST_W-1:0]   cand_p0;
    logic              sel_ok_p0;
    logic              inj_ok_p0;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction

    function automatic logic [ST_W-1:0] inject(input logic [ST_W-1:0]   st,
                                               input logic [WSEL_W-1:0] idx,
                                               input logic [WORD_W-1:0] data);
        logic [ST_W-1:0] r;
        r = st;
        for (int w = 0; w < NB_WORDS; w++) begin
            if (idx == WSEL_W'(w)) begin
                r[w*WORD_W +: WORD_W] = st[w*WORD_W +: WORD_W] ^ data;
            end
        end
        return r;
    endfunction

    // Stage p0: index checks, source mux and optional word injection.
    always_comb begin
        sel_ok_p0 = ({1'b0, bus.sel_i} < SRC_LIM);
        inj_ok_p0 = ({1'b0, bus.inj_word_i} < WORD_LIM);
        cand_p0   = '0;
        for (int s = 0; s < NB_SRC; s++) begin
            if (bus.sel_i == SEL_W'(s)) begin
                cand_p0 = bus.src_i[s*ST_W +: ST_W];
            end
        end
        if (bus.inj_en_i && inj_ok_p0) begin
            cand_p0 = inject(cand_p0, bus.inj_word_i, bus.inj_data_i);
        end
    end

    // Next-state logic: clear beats load; an illegal source blocks the capture.
    always_comb begin
        fsm_d     = fsm_p1;
        state_d   = state_p1;
        sel_err_d = sel_err_p1;
        cnt_d     = cnt_p1;
        if (bus.clear_i) begin
            fsm_d     = EMPTY;
            state_d   = '0;
            sel_err_d = 1'b0;
            cnt_d     = '0;
        end else if (bus.load_i) begin
            if (sel_ok_p0) begin
                fsm_d   = VALID;
                state_d = cand_p0;
                cnt_d   = sat_inc(cnt_p1);
                if (bus.inj_en_i && !inj_ok_p0) begin
                    sel_err_d = 1'b1;
                end
            end else begin
                sel_err_d = 1'b1;
            end
        end
    end

    // Stage p1: state register and status; reset discards any pending capture.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            fsm_p1     <= EMPTY;
            state_p1   <= '0;
            sel_err_p1 <= 1'b0;
            cnt_p1     <= '0;
        end else begin
            fsm_p1     <= fsm_d;
            state_p1   <= state_d;
            sel_err_p1 <= sel_err_d;
            cnt_p1     <= cnt_d;
        end
    end

    assign bus.state_o       = state_p1;
    assign bus.state_valid_o = (fsm_p1 == VALID);
    assign bus.sel_err_o     = sel_err_p1;
    assign bus.load_cnt_o    = cnt_p1;
endmodule

// File: tb/tb_ascon_state_select_reg.sv
// Directed bench for ascon_state_select_reg: a 4-source instance driven from
// a vector table, and a 3-source / 4-bit-counter instance for the illegal
// index and saturation sequences.
module tb_ascon_state_select_reg;
    localparam logic [63:0] P1 = 64'h1111_1111_1111_1111;
    localparam logic [63:0] P2 = 64'h2222_2222_2222_2222;
    localparam logic [63:0] P3 = 64'h3333_3333_3333_3333;
    localparam logic [63:0] P4 = 64'h4444_4444_4444_4444;

    logic clk;
    logic resetb;
    int   n_tests;
    int   n_fail;

    ascon_state_select_reg_if #(.NB_SRC(4), .NB_WORDS(5), .WORD_W(64), .CNT_W(8)) bus_a ();
    ascon_state_select_reg_if #(.NB_SRC(3), .NB_WORDS(5), .WORD_W(64), .CNT_W(4)) bus_b ();

    ascon_state_select_reg #(.NB_SRC(4), .NB_WORDS(5), .WORD_W(64), .CNT_W(8)) dut_a (
        .clock_i  (clk),
        .resetb_i (resetb),
        .bus      (bus_a)
    );

    ascon_state_select_reg #(.NB_SRC(3), .NB_WORDS(5), .WORD_W(64), .CNT_W(4)) dut_b (
        .clock_i  (clk),
        .resetb_i (resetb),
        .bus      (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   sel;
        logic         load;
        logic         clear;
        logic         inj_en;
        logic [2:0]   inj_word;
        logic [63:0]  inj_data;
        logic [319:0] exp_state;
        logic         exp_valid;
        logic         exp_err;
        logic [7:0]   exp_cnt;
    } vec_t;

    vec_t vecs[11];

    function automatic logic [319:0] fill(input logic [63:0] w);
        return {5{w}};
    endfunction

    function automatic vec_t mk(input logic [1:0] sel, input logic load, input logic clear,
                                input logic inj_en, input logic [2:0] inj_word,
                                input logic [63:0] inj_data, input logic [319:0] st,
                                input logic v, input logic e, input logic [7:0] c);
        vec_t r;
        r.sel = sel; r.load = load; r.clear = clear; r.inj_en = inj_en;
        r.inj_word = inj_word; r.inj_data = inj_data; r.exp_state = st;
        r.exp_valid = v; r.exp_err = e; r.exp_cnt = c;
        return r;
    endfunction

    task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [319:0] st, input logic v,
                         input logic e, input logic [7:0] c);
        chk({tag, ".state"}, bus_a.state_o, st);
        chk({tag, ".valid"}, 320'(bus_a.state_valid_o), 320'(v));
        chk({tag, ".err"},   320'(bus_a.sel_err_o), 320'(e));
        chk({tag, ".cnt"},   320'(bus_a.load_cnt_o), 320'(c));
    endtask

    task automatic chk_b(input string tag, input logic [319:0] st, input logic v,
                         input logic e, input logic [3:0] c);
        chk({tag, ".state"}, bus_b.state_o, st);
        chk({tag, ".valid"}, 320'(bus_b.state_valid_o), 320'(v));
        chk({tag, ".err"},   320'(bus_b.sel_err_o), 320'(e));
        chk({tag, ".cnt"},   320'(bus_b.load_cnt_o), 320'(c));
    endtask

    initial begin
        logic [319:0] e_inj0;
        logic [319:0] e_inj4;
        logic [63:0]  pat;
        int           exp_cnt;

        n_tests = 0;
        n_fail  = 0;
        pat     = P1;

        for (int s = 0; s < 4; s++)
            for (int w = 0; w < 5; w++)
                bus_a.src_i[(s*5+w)*64 +: 64] = pat * 64'(s + 1);
        for (int s = 0; s < 3; s++)
            for (int w = 0; w < 5; w++)
                bus_b.src_i[(s*5+w)*64 +: 64] = pat * 64'(s + 1);

        bus_a.sel_i = '0; bus_a.load_i = 1'b0; bus_a.clear_i = 1'b0;
        bus_a.inj_en_i = 1'b0; bus_a.inj_word_i = '0; bus_a.inj_data_i = '0;
        bus_b.sel_i = '0; bus_b.load_i = 1'b0; bus_b.clear_i = 1'b0;
        bus_b.inj_en_i = 1'b0; bus_b.inj_word_i = '0; bus_b.inj_data_i = '0;

        e_inj0 = fill(P2);
        e_inj0[63:0] = 64'hDDDD_DDDD_DDDD_DDDD;
        e_inj4 = fill(P1);
        e_inj4[319:256] = 64'h0;

        //             sel   ld    clr   inj   word  data                    state         v     e     cnt
        vecs[0]  = mk(2'd0, 1'b1, 1'b0, 1'b0, 3'd0, 64'h0,                  fill(P1),     1'b1, 1'b0, 8'd1);
        vecs[1]  = mk(2'd1, 1'b1, 1'b0, 1'b0, 3'd0, 64'h0,                  fill(P2),     1'b1, 1'b0, 8'd2);
        vecs[2]  = mk(2'd2, 1'b1, 1'b0, 1'b0, 3'd0, 64'h0,                  fill(P3),     1'b1, 1'b0, 8'd3);
        vecs[3]  = mk(2'd3, 1'b1, 1'b0, 1'b0, 3'd0, 64'h0,                  fill(P4),     1'b1, 1'b0, 8'd4);
        vecs[4]  = mk(2'd1, 1'b0, 1'b0, 1'b1, 3'd2, 64'hFFFF_0000_FFFF_0000, fill(P4),    1'b1, 1'b0, 8'd4);
        vecs[5]  = mk(2'd1, 1'b1, 1'b0, 1'b1, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, e_inj0,      1'b1, 1'b0, 8'd5);
        vecs[6]  = mk(2'd0, 1'b1, 1'b0, 1'b1, 3'd4, P1,                     e_inj4,       1'b1, 1'b0, 8'd6);
        vecs[7]  = mk(2'd2, 1'b1, 1'b0, 1'b1, 3'd5, 64'hFFFF_FFFF_FFFF_FFFF, fill(P3),    1'b1, 1'b1, 8'd7);
        vecs[8]  = mk(2'd3, 1'b1, 1'b0, 1'b0, 3'd0, 64'h0,                  fill(P4),     1'b1, 1'b1, 8'd8);
        vecs[9]  = mk(2'd1, 1'b1, 1'b1, 1'b0, 3'd0, 64'h0,                  320'h0,       1'b0, 1'b0, 8'd0);
        vecs[10] = mk(2'd2, 1'b1, 1'b0, 1'b0, 3'd0, 64'h0,                  fill(P3),     1'b1, 1'b0, 8'd1);

        // Power-on reset state
        resetb = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_a("rst_a", 320'h0, 1'b0, 1'b0, 8'd0);
        chk_b("rst_b", 320'h0, 1'b0, 1'b0, 4'd0);
        @(negedge clk);
        resetb = 1'b1;

        // Table-driven vectors on the 4-source instance
        for (int i = 0; i < 11; i++) begin
            bus_a.sel_i      = vecs[i].sel;
            bus_a.load_i     = vecs[i].load;
            bus_a.clear_i    = vecs[i].clear;
            bus_a.inj_en_i   = vecs[i].inj_en;
            bus_a.inj_word_i = vecs[i].inj_word;
            bus_a.inj_data_i = vecs[i].inj_data;
            @(posedge clk);
            #1;
            chk_a($sformatf("vec%0d", i), vecs[i].exp_state, vecs[i].exp_valid,
                  vecs[i].exp_err, vecs[i].exp_cnt);
        end

        // Asynchronous reset while a load is pending
        bus_a.sel_i = 2'd3; bus_a.load_i = 1'b1; bus_a.clear_i = 1'b0; bus_a.inj_en_i = 1'b0;
        @(negedge clk);
        resetb = 1'b0;
        #1;
        chk_a("async_rst", 320'h0, 1'b0, 1'b0, 8'd0);
        @(posedge clk);
        #1;
        chk_a("rst_hold_load", 320'h0, 1'b0, 1'b0, 8'd0);
        @(negedge clk);
        bus_a.load_i = 1'b0;
        resetb = 1'b1;
        @(posedge clk);
        #1;
        chk_a("rst_release", 320'h0, 1'b0, 1'b0, 8'd0);

        // Illegal source index on the 3-source instance
        bus_b.sel_i = 2'd0; bus_b.load_i = 1'b1;
        @(posedge clk); #1;
        chk_b("b_load0", fill(P1), 1'b1, 1'b0, 4'd1);
        bus_b.sel_i = 2'd3;
        @(posedge clk); #1;
        chk_b("b_illegal", fill(P1), 1'b1, 1'b1, 4'd1);
        bus_b.sel_i = 2'd1;
        @(posedge clk); #1;
        chk_b("b_after_err", fill(P2), 1'b1, 1'b1, 4'd2);

        // Counter saturation: 20 back-to-back loads
        bus_b.sel_i = 2'd2;
        exp_cnt = 2;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
            chk($sformatf("sat%0d", i), 320'(bus_b.load_cnt_o), 320'(exp_cnt));
        end
        chk_b("b_sat_end", fill(P3), 1'b1, 1'b1, 4'hF);

        // Clear wins over a simultaneous load
        bus_b.sel_i = 2'd0; bus_b.clear_i = 1'b1;
        @(posedge clk); #1;
        chk_b("b_clear", 320'h0, 1'b0, 1'b0, 4'd0);
        bus_b.clear_i = 1'b0; bus_b.load_i = 1'b0;
        @(posedge clk); #1;
        chk_b("b_idle", 320'h0, 1'b0, 1'b0, 4'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
